// File: rtl/mac_acc_norm_pkg.sv
// mac_pkg: shared definitions for the mac_acc_norm block.
//   - default widths (IN_W, ACC_W, MAN_W, EXP_W)
//   - FSM state enum {ST_ACC, ST_NORM, ST_OUT}
//   - sat_add: signed add clamped to a w-bit two's complement range
//   - man_max: largest positive mantissa, the rounding saturation point
package mac_pkg;

    localparam int IN_W_DEF  = 20;
    localparam int ACC_W_DEF = 28;
    localparam int MAN_W_DEF = 7;
    localparam int EXP_W_DEF = 5;

    // Working width for saturating arithmetic; wide enough that acc + sample
    // never wraps before the clamp is applied.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_NORM = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic                    ovf;
        logic signed [SAT_W-1:0] val;
    } sat_t;

    function automatic sat_t sat_add(input logic signed [SAT_W-1:0] a,
                                     input logic signed [SAT_W-1:0] b,
                                     input int                      w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t                    r;
        hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        r.val = a + b;
        r.ovf = 1'b0;
        if (r.val > hi) begin
            r.val = hi;
            r.ovf = 1'b1;
        end else if (r.val < lo) begin
            r.val = lo;
            r.ovf = 1'b1;
        end
        return r;
    endfunction

    function automatic int man_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/mac_acc_norm_if.sv
// mac_acc_norm_if: sample input and result output handshakes of mac_acc_norm.
//   in_vld/in_rdy/in_res/in_last          : sample stream into the block
//   out_vld/out_rdy/out_dat/out_exp/out_ovf : normalised result out of the block
//   master : the environment (drives samples, accepts results)
//   slave  : the mac_acc_norm block
interface mac_acc_norm_if
    import mac_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int EXP_W = EXP_W_DEF
);
    logic                    in_vld;
    logic                    in_rdy;
    logic signed [IN_W-1:0]  in_res;
    logic                    in_last;
    logic                    out_vld;
    logic                    out_rdy;
    logic signed [MAN_W-1:0] out_dat;
    logic [EXP_W-1:0]        out_exp;
    logic                    out_ovf;

    modport master (
        output in_vld, in_res, in_last, out_rdy,
        input  in_rdy, out_vld, out_dat, out_exp, out_ovf
    );

    modport slave (
        input  in_vld, in_res, in_last, out_rdy,
        output in_rdy, out_vld, out_dat, out_exp, out_ovf
    );
endinterface

// File: rtl/mac_acc_norm_lsc.sv
// mac_norm_lsc: combinational normaliser, accumulator -> block-float operand.
//   acc_i : signed accumulator value (ACC_W)
//   dat_o : signed mantissa (MAN_W), value = dat_o * 2**exp_o
//   exp_o : shift count, the smallest one that makes acc_i fit MAN_W bits
module mac_norm_lsc
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [MAN_W-1:0] dat_o,
    output logic [EXP_W-1:0]        exp_o
);
    localparam int SMAX = ACC_W - MAN_W;
    localparam logic signed [MAN_W:0] MAXC = (MAN_W + 1)'(man_max(MAN_W));

    // Round half up; only a positive value can round out of range.
    function automatic logic signed [MAN_W-1:0] round_sat(input logic signed [MAN_W-1:0] trunc,
                                                          input logic                    rbit);
        logic signed [MAN_W:0] sum;
        sum = {trunc[MAN_W-1], trunc} + {{MAN_W{1'b0}}, rbit};
        if (sum > MAXC) begin
            return MAN_W'(man_max(MAN_W));
        end
        return sum[MAN_W-1:0];
    endfunction

    // ext carries one guard bit below the LSB: after ext >>> s, bit 0 is
    // acc bit (s-1) (zero when s == 0) and bits [MAN_W:1] are the mantissa.
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] t;
    logic signed [ACC_W:0] sel;

    always_comb begin
        ext   = {acc_i, 1'b0};
        t     = '0;
        sel   = ext >>> SMAX;
        exp_o = EXP_W'(SMAX);
        // Descending scan so the last hit is the smallest fitting shift.
        for (int i = SMAX; i >= 0; i--) begin
            t = ext >>> i;
            if ((&t[ACC_W:MAN_W]) || !(|t[ACC_W:MAN_W])) begin
                sel   = t;
                exp_o = EXP_W'(i);
            end
        end
        dat_o = round_sat(sel[MAN_W:1], sel[0]);
    end
endmodule

// File: rtl/mac_acc_norm.sv
// mac_acc_norm: saturating vector accumulator with block-float normalised output.
//   clk : clock, all state on rising edge
//   rst : synchronous reset, active-high; aborts any vector / pending result
//   bus : mac_acc_norm_if.slave
//         in_vld/in_rdy/in_res/in_last  sample stream
//         out_vld/out_rdy               result handshake
//         out_dat/out_exp/out_ovf       mantissa, shift exponent, sticky saturation flag
module mac_acc_norm
    import mac_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mac_acc_norm_if.slave bus
);
    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic                    ovf_q;
    logic                    ovf_d;
    logic                    in_rdy_q;
    logic                    out_vld_q;
    logic signed [MAN_W-1:0] out_dat_q;
    logic [EXP_W-1:0]        out_exp_q;
    logic                    out_ovf_q;

    logic signed [IN_W-1:0]  in_res;
    logic signed [MAN_W-1:0] norm_dat;
    logic [EXP_W-1:0]        norm_exp;
    sat_t                    sat_r;

    assign in_res = bus.in_res;

    always_comb begin
        sat_r = sat_add({{(SAT_W - ACC_W){acc_q[ACC_W-1]}}, acc_q},
                        {{(SAT_W - IN_W){in_res[IN_W-1]}}, in_res},
                        ACC_W);
        acc_d = ACC_W'(sat_r.val);
        ovf_d = ovf_q | sat_r.ovf;
    end

    mac_norm_lsc #(
        .ACC_W (ACC_W),
        .MAN_W (MAN_W),
        .EXP_W (EXP_W)
    ) u_lsc (
        .acc_i (acc_q),
        .dat_o (norm_dat),
        .exp_o (norm_exp)
    );

    // in_rdy_q is high exactly while in ST_ACC, so in_vld alone qualifies
    // acceptance there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_exp_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (bus.in_vld) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_d;
                        if (bus.in_last) begin
                            state_q  <= ST_NORM;
                            in_rdy_q <= 1'b0;
                        end
                    end
                end
                ST_NORM: begin
                    out_dat_q <= norm_dat;
                    out_exp_q <= norm_exp;
                    out_ovf_q <= ovf_q;
                    out_vld_q <= 1'b1;
                    state_q   <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_rdy) begin
                        acc_q     <= '0;
                        ovf_q     <= 1'b0;
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state_q   <= ST_ACC;
                    end
                end
                default: begin
                    state_q  <= ST_ACC;
                    in_rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_rdy  = in_rdy_q;
    assign bus.out_vld = out_vld_q;
    assign bus.out_dat = out_dat_q;
    assign bus.out_exp = out_exp_q;
    assign bus.out_ovf = out_ovf_q;
endmodule

// File: tb/tb_mac_acc_norm.sv
// tb_mac_acc_norm: directed and randomized bench for mac_acc_norm.
//   dut_a : default widths (ACC_W=28)
//   dut_b : ACC_W=22, used for the accumulator saturation case
module tb_mac_acc_norm;
    import mac_pkg::*;

    localparam int IN_W    = 20;
    localparam int MAN_W   = 7;
    localparam int EXP_W   = 5;
    localparam int ACC_W   = 28;
    localparam int ACC_W_S = 22;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_acc_norm_if #(.IN_W(IN_W), .MAN_W(MAN_W), .EXP_W(EXP_W)) ifa ();
    mac_acc_norm_if #(.IN_W(IN_W), .MAN_W(MAN_W), .EXP_W(EXP_W)) ifb ();

    mac_acc_norm #(.IN_W(IN_W), .ACC_W(ACC_W), .MAN_W(MAN_W), .EXP_W(EXP_W))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mac_acc_norm #(.IN_W(IN_W), .ACC_W(ACC_W_S), .MAN_W(MAN_W), .EXP_W(EXP_W))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int     n_chk = 0;
    int     n_err = 0;
    longint vq[$];

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer sum clamped per sample, then the smallest
    // shift that brings the value into [-64, 63], round half up via
    // floor((acc + 2**(s-1)) / 2**s), cap at +63.
    function automatic void ref_vec(input int accw, output int dat, output int ex,
                                    output int ov);
        longint hi, lo, acc, r;
        int     s;
        hi  = (longint'(1) <<< (accw - 1)) - 1;
        lo  = -hi - 1;
        acc = 0;
        ov  = 0;
        foreach (vq[i]) begin
            acc += vq[i];
            if (acc > hi) begin
                acc = hi;
                ov  = 1;
            end else if (acc < lo) begin
                acc = lo;
                ov  = 1;
            end
        end
        s = 0;
        while (s < accw - MAN_W && ((acc >>> s) > 63 || (acc >>> s) < -64)) s++;
        r = (s == 0) ? acc : ((acc + (longint'(1) <<< (s - 1))) >>> s);
        if (r > 63) r = 63;
        dat = int'(r);
        ex  = s;
    endfunction

    task automatic push_a(input longint v, input bit last);
        int g;
        g = 0;
        @(negedge clk);
        ifa.in_vld  = 1'b1;
        ifa.in_res  = IN_W'(v);
        ifa.in_last = last;
        while (!ifa.in_rdy && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("push_timeout", 1, 0);
        @(posedge clk);
    endtask

    task automatic idle_a();
        @(negedge clk);
        ifa.in_vld  = 1'b0;
        ifa.in_last = 1'b0;
    endtask

    // Sends vq to dut_a, waits for the result, holds out_rdy low for
    // 'stall' cycles while poking in_vld, then completes the handshake.
    task automatic run_vec_a(input string tag, input int xd, input int xe, input int xo,
                             input int stall, input bit gaps);
        int n;
        foreach (vq[i]) begin
            if (gaps && $urandom_range(0, 4) == 0) idle_a();
            push_a(vq[i], i == vq.size() - 1);
        end
        @(negedge clk);
        ifa.in_vld  = 1'b0;
        ifa.in_last = 1'b0;
        n = 1;
        while (!ifa.out_vld && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_vld"}, ifa.out_vld, 1);
        chk({tag, "_lat"}, n, 2);
        chk({tag, "_dat"}, ifa.out_dat, xd);
        chk({tag, "_exp"}, ifa.out_exp, xe);
        chk({tag, "_ovf"}, ifa.out_ovf, xo);
        for (int k = 0; k < stall; k++) begin
            ifa.in_vld  = 1'b1;
            ifa.in_res  = IN_W'(1000 + k);
            ifa.in_last = k[0];
            @(negedge clk);
            chk({tag, "_hold_dat"}, ifa.out_dat, xd);
            chk({tag, "_hold_exp"}, ifa.out_exp, xe);
            chk({tag, "_hold_vld"}, ifa.out_vld, 1);
            chk({tag, "_hold_rdy"}, ifa.in_rdy, 0);
        end
        ifa.in_vld  = 1'b0;
        ifa.in_last = 1'b0;
        ifa.out_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifa.out_rdy = 1'b0;
        chk({tag, "_done_vld"}, ifa.out_vld, 0);
        chk({tag, "_done_rdy"}, ifa.in_rdy, 1);
    endtask

    task automatic wait_b(input string tag, input int xd, input int xe, input int xo);
        int n;
        n = 0;
        while (!ifb.out_vld && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_vld"}, ifb.out_vld, 1);
        chk({tag, "_dat"}, ifb.out_dat, xd);
        chk({tag, "_exp"}, ifb.out_exp, xe);
        chk({tag, "_ovf"}, ifb.out_ovf, xo);
        ifb.out_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifb.out_rdy = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ed, ee, eo, len, mode;
        longint v;

        rst         = 1'b1;
        ifa.in_vld  = 1'b0; ifa.in_res = '0; ifa.in_last = 1'b0; ifa.out_rdy = 1'b0;
        ifb.in_vld  = 1'b0; ifb.in_res = '0; ifb.in_last = 1'b0; ifb.out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_rdy", ifa.in_rdy, 1);
        chk("rst_out_vld", ifa.out_vld, 0);
        chk("rst_out_dat", ifa.out_dat, 0);
        chk("rst_out_exp", ifa.out_exp, 0);
        chk("rst_out_ovf", ifa.out_ovf, 0);

        vq = '{5};             run_vec_a("single", 5, 0, 0, 0, 0);
        vq = '{100, 200, -50}; run_vec_a("vector", 63, 2, 0, 0, 0);
        vq = '{127};           run_vec_a("rsat_pos", 63, 1, 0, 0, 0);
        vq = '{-200};          run_vec_a("rnd_neg", -50, 2, 0, 0, 0);
        vq = '{-64};           run_vec_a("neg_min", -64, 0, 0, 0, 0);
        vq = '{0};             run_vec_a("zero", 0, 0, 0, 0, 0);
        vq = '{-65};           run_vec_a("neg_rnd", -32, 1, 0, 0, 0);

        vq = '{10, 20, 30};    run_vec_a("bp", 60, 0, 0, 5, 0);
        vq = '{10, 20};        run_vec_a("bp_next", 30, 0, 0, 0, 0);

        // Saturation on the narrow accumulator.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ifb.in_vld  = 1'b1;
            ifb.in_res  = IN_W'(524287);
            ifb.in_last = (i == 4);
        end
        @(negedge clk);
        ifb.in_vld = 1'b0; ifb.in_last = 1'b0;
        wait_b("ovf", 63, 15, 1);
        ifb.in_vld = 1'b1; ifb.in_res = IN_W'(3); ifb.in_last = 1'b1;
        @(negedge clk);
        ifb.in_vld = 1'b0; ifb.in_last = 1'b0;
        wait_b("ovf_next", 3, 0, 0);

        // Reset mid-vector discards the partial sum.
        push_a(1000, 0); push_a(2000, 0); push_a(3000, 0);
        idle_a();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_in_rdy", ifa.in_rdy, 1);
        chk("mrst_out_vld", ifa.out_vld, 0);
        vq = '{7};             run_vec_a("mrst", 7, 0, 0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            mode = $urandom_range(0, 4);
            len  = (mode < 2) ? $urandom_range(280, 300) : $urandom_range(1, 300);
            vq.delete();
            for (int i = 0; i < len; i++) begin
                if (mode == 0)      v = longint'($urandom_range(500000, 524287));
                else if (mode == 1) v = -longint'($urandom_range(500000, 524288));
                else                v = longint'($urandom_range(0, 1048575)) - 524288;
                vq.push_back(v);
            end
            ref_vec(ACC_W, ed, ee, eo);
            run_vec_a($sformatf("rnd%0d", n), ed, ee, eo, $urandom_range(0, 3), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
